scores_high_score_manager: RTL and testbench

Upstream controller for the scores SD communicator. It owns the running game score and the persistent high score. After SD init it requests the previous high score, counts points during play, compares at game over, and requests a save when a new record is set. It presents level-held requests and 16-bit data to the communicator, and exposes score, high score and status to the display and game logic.

---
 rtl/scores_high_score_manager_pkg.sv | 25 ++
 rtl/scores_high_score_manager_if.sv | 26 ++
 rtl/scores_timeout_counter.sv | 32 +++
 rtl/scores_high_score_manager.sv | 162 ++++++++++++++++
 tb/tb_scores_high_score_manager.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scores_high_score_manager_pkg.sv
// Shared types for the scores high-score manager: score width, FSM encoding
// and default tuning parameters.
package scores_high_score_manager_pkg;

    localparam int SCORE_W                = 16;
    localparam int DEFAULT_MAX_SCORE      = 9999;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100_000_000;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        ST_WAIT_SD,
        ST_LOAD,
        ST_READY,
        ST_PLAY,
        ST_COMPARE,
        ST_SAVE
    } state_t;

    // Only READY and PLAY are idle from the game logic's point of view.
    function automatic logic is_busy(state_t s);
        return !(s == ST_READY || s == ST_PLAY);
    endfunction

endpackage

// File: rtl/scores_high_score_manager_if.sv
// Level-held request/finish handshake between the high-score manager (master)
// and the scores SD communicator (slave).
interface scores_high_score_manager_if;
    import scores_high_score_manager_pkg::*;

    logic   SD_HAS_INITIALIZED;
    logic   TO_GET_PREVIOUS_SCORES;
    logic   GET_PREVIOUS_SCORES_FINISH;
    score_t PREVIOUS_SCORES;
    logic   TO_SAVE_SCORES;
    logic   SAVE_SCORES_FINISH;
    score_t SCORES_TO_WRITE;

    modport master (
        input  SD_HAS_INITIALIZED, GET_PREVIOUS_SCORES_FINISH, PREVIOUS_SCORES,
               SAVE_SCORES_FINISH,
        output TO_GET_PREVIOUS_SCORES, TO_SAVE_SCORES, SCORES_TO_WRITE
    );

    modport slave (
        output SD_HAS_INITIALIZED, GET_PREVIOUS_SCORES_FINISH, PREVIOUS_SCORES,
               SAVE_SCORES_FINISH,
        input  TO_GET_PREVIOUS_SCORES, TO_SAVE_SCORES, SCORES_TO_WRITE
    );

endinterface

// File: rtl/scores_timeout_counter.sv
// Cycle counter that flags expiry once it has counted TIMEOUT_CYCLES-1 enabled
// cycles since the last clear; shared by the load and save phases.
module scores_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/scores_high_score_manager.sv
// Owns the running score and persistent high score; loads the previous record
// from SD after init and requests a single save when a new record is set.
module scores_high_score_manager
    import scores_high_score_manager_pkg::*;
#(
    parameter int MAX_SCORE      = DEFAULT_MAX_SCORE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                               CLK,
    input  logic                               RESET,
    scores_high_score_manager_if.master        sd,
    input  logic                               GAME_START,
    input  logic                               SCORE_INC,
    input  logic                               GAME_OVER,
    output score_t                             CURRENT_SCORE,
    output score_t                             HIGH_SCORE,
    output logic                               NEW_RECORD,
    output logic                               BUSY,
    output logic                               LOAD_FAILED,
    output logic                               SAVE_FAILED
);

    localparam score_t MAX_S = score_t'(MAX_SCORE);

    state_t state, state_n;
    logic   to_get_q, to_get_n;
    logic   to_save_q, to_save_n;
    score_t write_q, write_n;
    score_t cur_n, high_n;
    logic   new_rec_n, busy_n, load_failed_n, save_failed_n;
    logic   save_used, save_used_n;
    logic   tmr_clear, tmr_en, tmr_expired;

    scores_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // The counter runs through WAIT_SD and LOAD back to back, and restarts for SAVE.
    assign tmr_clear = (state == ST_COMPARE);
    assign tmr_en    = (state == ST_WAIT_SD) || (state == ST_LOAD) || (state == ST_SAVE);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n       = state;
        to_get_n      = to_get_q;
        to_save_n     = to_save_q;
        write_n       = write_q;
        cur_n         = CURRENT_SCORE;
        high_n        = HIGH_SCORE;
        new_rec_n     = NEW_RECORD;
        load_failed_n = LOAD_FAILED;
        save_failed_n = SAVE_FAILED;
        save_used_n   = save_used;

        case (state)
            ST_WAIT_SD: begin
                if (tmr_expired) begin
                    high_n        = '0;
                    load_failed_n = 1'b1;
                    state_n       = ST_READY;
                end else if (sd.SD_HAS_INITIALIZED) begin
                    to_get_n = 1'b1;
                    state_n  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // FINISH takes priority over a coincident timeout.
                if (sd.GET_PREVIOUS_SCORES_FINISH) begin
                    high_n   = (sd.PREVIOUS_SCORES > MAX_S) ? '0 : sd.PREVIOUS_SCORES;
                    to_get_n = 1'b0;
                    state_n  = ST_READY;
                end else if (tmr_expired) begin
                    high_n        = '0;
                    load_failed_n = 1'b1;
                    to_get_n      = 1'b0;
                    state_n       = ST_READY;
                end
            end
            ST_READY: begin
                if (GAME_START) begin
                    cur_n     = '0;
                    new_rec_n = 1'b0;
                    state_n   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (SCORE_INC && CURRENT_SCORE < MAX_S) begin
                    cur_n = CURRENT_SCORE + 1'b1;
                end
                if (GAME_OVER) begin
                    state_n = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                state_n = ST_READY;
                if (CURRENT_SCORE > HIGH_SCORE) begin
                    high_n    = CURRENT_SCORE;
                    new_rec_n = 1'b1;
                    write_n   = CURRENT_SCORE;
                    // The communicator's write path is one-shot per reset.
                    if (!save_used && !LOAD_FAILED) begin
                        to_save_n = 1'b1;
                        state_n   = ST_SAVE;
                    end
                end
            end
            ST_SAVE: begin
                if (sd.SAVE_SCORES_FINISH) begin
                    to_save_n   = 1'b0;
                    save_used_n = 1'b1;
                    state_n     = ST_READY;
                end else if (tmr_expired) begin
                    to_save_n     = 1'b0;
                    save_failed_n = 1'b1;
                    save_used_n   = 1'b1;
                    state_n       = ST_READY;
                end
            end
            default: state_n = ST_WAIT_SD;
        endcase

        busy_n = is_busy(state_n);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_WAIT_SD;
            to_get_q      <= 1'b0;
            to_save_q     <= 1'b0;
            write_q       <= '0;
            CURRENT_SCORE <= '0;
            HIGH_SCORE    <= '0;
            NEW_RECORD    <= 1'b0;
            BUSY          <= 1'b1;
            LOAD_FAILED   <= 1'b0;
            SAVE_FAILED   <= 1'b0;
            save_used     <= 1'b0;
        end else begin
            state         <= state_n;
            to_get_q      <= to_get_n;
            to_save_q     <= to_save_n;
            write_q       <= write_n;
            CURRENT_SCORE <= cur_n;
            HIGH_SCORE    <= high_n;
            NEW_RECORD    <= new_rec_n;
            BUSY          <= busy_n;
            LOAD_FAILED   <= load_failed_n;
            SAVE_FAILED   <= save_failed_n;
            save_used     <= save_used_n;
        end
    end

    assign sd.TO_GET_PREVIOUS_SCORES = to_get_q;
    assign sd.TO_SAVE_SCORES         = to_save_q;
    assign sd.SCORES_TO_WRITE        = write_q;

endmodule

// File: tb/tb_scores_high_score_manager.sv
// Self-checking bench for scores_high_score_manager: directed scenarios plus
// randomized sessions scored against a game-history reference model.
module tb_scores_high_score_manager;
    import scores_high_score_manager_pkg::*;

    localparam int MAX_SCORE      = 9999;
    localparam int TIMEOUT_CYCLES = 16;

    logic   CLK = 1'b0;
    logic   RESET;
    logic   GAME_START, SCORE_INC, GAME_OVER;
    score_t CURRENT_SCORE, HIGH_SCORE;
    logic   NEW_RECORD, BUSY, LOAD_FAILED, SAVE_FAILED;

    scores_high_score_manager_if sd_if ();

    scores_high_score_manager #(
        .MAX_SCORE      (MAX_SCORE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .sd            (sd_if),
        .GAME_START    (GAME_START),
        .SCORE_INC     (SCORE_INC),
        .GAME_OVER     (GAME_OVER),
        .CURRENT_SCORE (CURRENT_SCORE),
        .HIGH_SCORE    (HIGH_SCORE),
        .NEW_RECORD    (NEW_RECORD),
        .BUSY          (BUSY),
        .LOAD_FAILED   (LOAD_FAILED),
        .SAVE_FAILED   (SAVE_FAILED)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the manager should know after each game.
    int m_high;
    bit m_load_failed, m_save_used, m_save_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset;
        RESET      = 1'b1;
        GAME_START = 1'b0;
        SCORE_INC  = 1'b0;
        GAME_OVER  = 1'b0;
        sd_if.SD_HAS_INITIALIZED         = 1'b0;
        sd_if.GET_PREVIOUS_SCORES_FINISH = 1'b0;
        sd_if.PREVIOUS_SCORES            = '0;
        sd_if.SAVE_SCORES_FINISH         = 1'b0;
        tick;
        tick;
        check("rst_busy",     BUSY, 1);
        check("rst_cur",      CURRENT_SCORE, 0);
        check("rst_high",     HIGH_SCORE, 0);
        check("rst_new_rec",  NEW_RECORD, 0);
        check("rst_load_f",   LOAD_FAILED, 0);
        check("rst_save_f",   SAVE_FAILED, 0);
        check("rst_get_req",  sd_if.TO_GET_PREVIOUS_SCORES, 0);
        check("rst_save_req", sd_if.TO_SAVE_SCORES, 0);
        RESET = 1'b0;
        m_high        = 0;
        m_load_failed = 1'b0;
        m_save_used   = 1'b0;
        m_save_failed = 1'b0;
    endtask

    task automatic do_load(input int prev, input int delay);
        repeat (4) tick;
        sd_if.SD_HAS_INITIALIZED = 1'b1;
        tick;
        check("load_req_rise", sd_if.TO_GET_PREVIOUS_SCORES, 1);
        repeat (delay) tick;
        check("load_req_held", sd_if.TO_GET_PREVIOUS_SCORES, 1);
        check("load_busy",     BUSY, 1);
        sd_if.PREVIOUS_SCORES            = score_t'(prev);
        sd_if.GET_PREVIOUS_SCORES_FINISH = 1'b1;
        tick;
        m_high = (prev > MAX_SCORE) ? 0 : prev;
        check("load_req_drop", sd_if.TO_GET_PREVIOUS_SCORES, 0);
        check("load_high",     HIGH_SCORE, m_high);
        check("load_idle",     BUSY, 0);
        check("load_not_fail", LOAD_FAILED, 0);
    endtask

    // save_delay < 0 means the communicator never finishes and the save times out.
    task automatic play_game(input int n, input bit merge, input int save_delay);
        int  score;
        bit  record, exp_save;
        int  cyc;
        GAME_START = 1'b1;
        tick;
        GAME_START = 1'b0;
        check("start_cur",     CURRENT_SCORE, 0);
        check("start_new_rec", NEW_RECORD, 0);
        check("start_busy",    BUSY, 0);
        for (int i = 0; i < n; i++) begin
            SCORE_INC = 1'b1;
            tick;
            SCORE_INC = 1'b0;
            if (n <= 1000 && $urandom_range(3) == 0) tick;
        end
        GAME_OVER = 1'b1;
        SCORE_INC = merge;
        tick;
        GAME_OVER = 1'b0;
        SCORE_INC = 1'b0;
        score = n + int'(merge);
        if (score > MAX_SCORE) score = MAX_SCORE;
        check("final_score",  CURRENT_SCORE, score);
        check("compare_busy", BUSY, 1);
        tick;
        record   = (score > m_high);
        exp_save = record && !m_save_used && !m_load_failed;
        if (record) m_high = score;
        check("cmp_high",     HIGH_SCORE, m_high);
        check("cmp_new_rec",  NEW_RECORD, record);
        check("cmp_save_req", sd_if.TO_SAVE_SCORES, exp_save);
        if (!exp_save) begin
            check("cmp_idle", BUSY, 0);
        end else begin
            check("save_data", sd_if.SCORES_TO_WRITE, score);
            if (save_delay >= 0) begin
                repeat (save_delay) tick;
                check("save_req_held",  sd_if.TO_SAVE_SCORES, 1);
                check("save_data_held", sd_if.SCORES_TO_WRITE, score);
                sd_if.SAVE_SCORES_FINISH = 1'b1;
                tick;
                sd_if.SAVE_SCORES_FINISH = 1'b0;
                check("save_req_drop", sd_if.TO_SAVE_SCORES, 0);
            end else begin
                cyc = 0;
                while (sd_if.TO_SAVE_SCORES === 1'b1 && cyc < 40) begin
                    tick;
                    cyc++;
                end
                check("save_timeout_cycles", cyc, TIMEOUT_CYCLES);
                m_save_failed = 1'b1;
            end
            m_save_used = 1'b1;
            check("save_idle",   BUSY, 0);
            check("save_failed", SAVE_FAILED, m_save_failed);
            check("save_high",   HIGH_SCORE, m_high);
        end
    endtask

    initial begin
        int cyc;
        int prev;

        // Load 120, record 125 with save, then a tie and a post-save record.
        apply_reset;
        do_load(120, 4);
        SCORE_INC = 1'b1;
        GAME_OVER = 1'b1;
        tick;
        SCORE_INC = 1'b0;
        GAME_OVER = 1'b0;
        check("ready_ignores_inc", CURRENT_SCORE, 0);
        check("ready_ignores_go",  BUSY, 0);
        play_game(125, 1'b0, 3);
        play_game(125, 1'b0, 0);
        play_game(200, 1'b0, 0);
        check("one_shot_high", HIGH_SCORE, 200);

        // Out-of-range load value is sanitised.
        apply_reset;
        do_load(16'hFFFF, 2);

        // Load timeout: no FINISH, expiry at cycle 16 after reset.
        apply_reset;
        cyc = 0;
        repeat (4) begin tick; cyc++; end
        sd_if.SD_HAS_INITIALIZED = 1'b1;
        while (LOAD_FAILED !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        check("load_timeout_cycle", cyc, TIMEOUT_CYCLES);
        check("load_timeout_req",   sd_if.TO_GET_PREVIOUS_SCORES, 0);
        check("load_timeout_high",  HIGH_SCORE, 0);
        check("load_timeout_idle",  BUSY, 0);
        m_load_failed = 1'b1;
        play_game(50, 1'b1, 0);

        // Merged increment with GAME_OVER, then saturation.
        apply_reset;
        do_load(120, 0);
        play_game(120, 1'b1, 5);
        check("merge_high", HIGH_SCORE, 121);
        play_game(10000, 1'b0, 0);

        // Save timeout, then a later record must not save.
        apply_reset;
        prev = int'($urandom_range(300));
        do_load(prev, int'($urandom_range(5)));
        play_game(m_high + 1 + int'($urandom_range(20)), 1'b0, -1);
        play_game(m_high + 1 + int'($urandom_range(20)), 1'b0, 0);

        // Asynchronous reset while a save request is held.
        apply_reset;
        do_load(10, 1);
        GAME_START = 1'b1;
        tick;
        GAME_START = 1'b0;
        repeat (20) begin
            SCORE_INC = 1'b1;
            tick;
        end
        SCORE_INC = 1'b0;
        GAME_OVER = 1'b1;
        tick;
        GAME_OVER = 1'b0;
        tick;
        check("pre_rst_save_req", sd_if.TO_SAVE_SCORES, 1);
        #2 RESET = 1'b1;
        #1;
        check("async_save_req", sd_if.TO_SAVE_SCORES, 0);
        check("async_busy",     BUSY, 1);
        check("async_high",     HIGH_SCORE, 0);
        check("async_cur",      CURRENT_SCORE, 0);
        check("async_new_rec",  NEW_RECORD, 0);

        // Randomized sessions.
        repeat (4) begin
            apply_reset;
            if ($urandom_range(3) == 0) prev = int'($urandom_range(16'hFFFF, MAX_SCORE + 1));
            else                        prev = int'($urandom_range(500));
            do_load(prev, int'($urandom_range(5)));
            repeat (4) begin
                play_game(int'($urandom_range(600)), 1'($urandom_range(1)),
                          ($urandom_range(3) == 0) ? -1 : int'($urandom_range(10)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
